wma_seq: RTL and testbench
==========================

# wma_seq

Stream sequencer for the weighted-moving-average filter datapath. The filter consumes one sample on every clock and has no stall input, so this block buffers bursty upstream samples in a small FIFO. It presents them to the filter as a gap-free stream, and clears the filter history between bursts. It also tags which filter outputs are valid: it suppresses warm-up outputs and handles underrun. It sits between the sample source and the filter's `x`/`y`/reset pins.

## Interface
- `N`, 8: sample width (filter `x`/`y` width)
- `TAPS`, 4: filter window length; number of samples before an output is full-window
- `LAT`, 1: cycles from sample on `filt_x` to its result on `filt_y` (≥1)
- `DEPTH`, 8: input FIFO depth, power of 2, ≥ `START_LVL`
- `START_LVL`, 4: FIFO occupancy required to start a burst (1..`DEPTH`)

- `clk` in 1: clock. One clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in N: upstream sample
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: FIFO not full; a write occurs when `in_valid && in_ready`
- `enable` in 1: run request
- `filt_x` out N: registered sample to the filter
- `filt_rst_n` out 1: active-low synchronous clear of filter history (registered)
- `filt_y` in N: filter output
- `out_data` out N: equals `filt_y` (pass-through)
- `out_valid` out 1: `out_data` is a full-window result of a real sample
- `busy` out 1: state ≠ IDLE
- `err_underrun` out 1: sticky; FIFO ran empty during RUN
- `sample_cnt` out 16: samples issued since the last IDLE exit, saturating at 0xFFFF

## Operation
- FIFO: `DEPTH` entries with a registered occupancy count. A write and a pop may occur in the same cycle; occupancy is unchanged. Writes are accepted in every state.
- FSM states: IDLE, RUN, FLUSH.
- **IDLE**
  - `filt_rst_n`=0, `filt_x`=0, no pops.
  - Moves to RUN when `enable && count >= START_LVL`.
  - On that transition: clear `err_underrun`, clear `sample_cnt`, clear the warm-up counter.
- **RUN**
  - `filt_rst_n`=1. Pops one sample per cycle into `filt_x`. `sample_cnt` increments on each pop.
  - When `enable`=0: stop popping, `filt_x`←0, go to FLUSH.
  - When a pop is needed and `count`=0: set `err_underrun`, `filt_x`←0, go to FLUSH.
  - A write in the same cycle as an empty-FIFO pop attempt does not prevent the underrun.
- **FLUSH**
  - `filt_x`=0. Waits `LAT` cycles so in-flight results emerge, then goes to IDLE.
  - `enable` is ignored in FLUSH.
- **Validity tracking**
  - An issue flag is set for each popped sample. It is delayed `LAT` cycles by a shift register.
  - The flag is qualified by a warm-up counter: the k-th issued sample (0-based) is marked only if k ≥ `TAPS`−1.
  - `out_valid` = delayed qualified flag.
  - Zeros fed in FLUSH and IDLE are never marked valid.
- **Reset**: `rst` mid-operation discards FIFO contents and returns to IDLE on the next edge.

## Timing
- Reset values:
  - `in_ready`=1, `filt_x`=0, `filt_rst_n`=0, `out_valid`=0, `busy`=0, `err_underrun`=0, `sample_cnt`=0, FIFO empty, state IDLE.
  - `out_data` follows `filt_y`.
- Sample flow:
  - A sample written at edge t can be popped in the cycle after t.
  - A pop decided in cycle c appears on `filt_x` from edge c+1.
  - Its result appears on `filt_y`/`out_data` with `out_valid` `LAT` cycles later.
- Start: the IDLE→RUN edge also drives `filt_rst_n` to 1 and `filt_x` to the first sample.
- In-burst output: `out_valid` is continuous from the `TAPS`-th sample until the burst ends.
- FLUSH length: exactly `LAT` cycles.
- Restart: a new burst needs at least one IDLE cycle (`filt_rst_n`=0) before the next RUN.
- `in_ready` is combinational from occupancy: low only when count=`DEPTH`.

## Configuration
- `WMA_SEQ_HOLD_EN` defined:
  - Underrun in RUN does not leave RUN. `filt_x` repeats the last issued sample and `err_underrun` is set.
  - Repeated samples are not counted in `sample_cnt` and are not marked valid. The warm-up counter continues counting real samples only.
  - RUN ends only when `enable`=0.
- `WMA_SEQ_HOLD_EN` not defined: underrun goes to FLUSH as described in Operation.

## Test plan
All tests use defaults (`TAPS`=4, `LAT`=1, `DEPTH`=8, `START_LVL`=4).
- **Reset:** assert `rst` 2 cycles → all outputs at their reset values, `in_ready`=1, `busy`=0.
- **Fill with enable low:** `enable`=0, write 0x01..0x09 back-to-back → 8 accepted, `in_ready`=0 on the 9th, `busy` stays 0.
- **Single burst:**
  - Stimulus: `enable`=1, then write 0x01..0x08 one per cycle.
  - Expected: RUN starts after the 4th write; `filt_x` = 01..08 on consecutive cycles; `out_valid`=1 for exactly 5 cycles, for samples 04..08.
  - Then `err_underrun`=1, FLUSH for 1 cycle, IDLE; `sample_cnt`=8.
- **Enable drop:** pre-load 8 samples, `enable`=1, drop `enable` after 3 pops → `filt_x`=0 next cycle, no `out_valid`, FLUSH 1 cycle, IDLE, `err_underrun`=0, 5 entries remain.
- **Reset mid-RUN:** assert `rst` mid-RUN → next edge: IDLE, FIFO empty, `filt_rst_n`=0, `out_valid`=0.
- **`WMA_SEQ_HOLD_EN` hold:**
  - Stimulus: 4 samples, then a gap of 2 cycles, then 2 more.
  - Expected: `filt_x` holds 04 for 2 cycles with `err_underrun`=1 and state still RUN; `out_valid` low for the hold cycles; `sample_cnt`=6.

Source files
------------

// File: rtl/wma_seq.sv
// Stream sequencer for the weighted-moving-average filter: input FIFO, gap-free issue, warm-up/underrun tagging.
// Optional macro WMA_SEQ_HOLD_EN: on underrun, stay in RUN and repeat the last sample instead of flushing.
module wma_seq #(
    parameter int N         = 8,
    parameter int TAPS      = 4,
    parameter int LAT       = 1,
    parameter int DEPTH     = 8,
    parameter int START_LVL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         enable,
    output logic [N-1:0] filt_x,
    output logic         filt_rst_n,
    input  logic [N-1:0] filt_y,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         busy,
    output logic         err_underrun,
    output logic [15:0]  sample_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TAPS + 1);
    localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] START_C    = CW'(START_LVL);
    localparam logic [WW-1:0] WARM_ZERO  = WW'(0);
    localparam logic [WW-1:0] WARM_ONE   = WW'(1);
    localparam logic [WW-1:0] WARM_MAX   = WW'(TAPS - 1);
    localparam logic [FW-1:0] FLUSH_ZERO = FW'(0);
    localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    logic [N-1:0]   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    state_t         state_r;
    logic [FW-1:0]  flush_cnt_r;
    logic [WW-1:0]  warm_cnt_r;
    logic           iss_r;
    logic [LAT-1:0] vld_pipe_r;
    logic [N-1:0]   filt_x_r;
    logic           filt_rst_n_r;
    logic           err_underrun_r;
    logic [15:0]    sample_cnt_r;

    logic           wr_en_s;
    logic           empty_s;
    logic           start_s;
    logic           pop_s;
    logic           qual_s;
    logic [WW-1:0]  warm_base_s;
    logic [WW-1:0]  warm_next_s;

    assign empty_s  = (count_r == CNT_ZERO);
    assign in_ready = (count_r != DEPTH_C);
    assign wr_en_s  = in_valid && in_ready;
    assign start_s  = (state_r == IDLE) && enable && (count_r >= START_C);

    // Pop decision and warm-up qualification; a burst start counts from sample zero.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = start_s;
            RUN:     pop_s = enable && !empty_s;
            FLUSH:   pop_s = 1'b0;
            default: pop_s = 1'b0;
        endcase
        if (start_s) begin
            warm_base_s = WARM_ZERO;
        end else begin
            warm_base_s = warm_cnt_r;
        end
        if (warm_base_s == WARM_MAX) begin
            warm_next_s = warm_base_s;
        end else begin
            warm_next_s = warm_base_s + WARM_ONE;
        end
        qual_s = pop_s && (warm_base_s >= WARM_MAX);
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer FSM with registered filter controls and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            flush_cnt_r    <= FLUSH_ZERO;
            warm_cnt_r     <= WARM_ZERO;
            iss_r          <= 1'b0;
            filt_x_r       <= {N{1'b0}};
            filt_rst_n_r   <= 1'b0;
            err_underrun_r <= 1'b0;
            sample_cnt_r   <= 16'd0;
        end else begin
            iss_r <= qual_s;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r        <= RUN;
                        filt_rst_n_r   <= 1'b1;
                        filt_x_r       <= mem_r[rd_ptr_r];
                        err_underrun_r <= 1'b0;
                        sample_cnt_r   <= 16'd1;
                        warm_cnt_r     <= warm_next_s;
                    end else begin
                        filt_rst_n_r <= 1'b0;
                        filt_x_r     <= {N{1'b0}};
                    end
                end
                RUN: begin
                    if (!enable) begin
                        filt_x_r    <= {N{1'b0}};
                        state_r     <= FLUSH;
                        flush_cnt_r <= FLUSH_INIT;
                    end else if (empty_s) begin
                        err_underrun_r <= 1'b1;
`ifdef WMA_SEQ_HOLD_EN
                        filt_x_r       <= filt_x_r;
`else
                        filt_x_r       <= {N{1'b0}};
                        state_r        <= FLUSH;
                        flush_cnt_r    <= FLUSH_INIT;
`endif
                    end else begin
                        filt_x_r   <= mem_r[rd_ptr_r];
                        warm_cnt_r <= warm_next_s;
                        if (sample_cnt_r != 16'hFFFF) begin
                            sample_cnt_r <= sample_cnt_r + 16'd1;
                        end
                    end
                end
                FLUSH: begin
                    filt_x_r <= {N{1'b0}};
                    if (flush_cnt_r == FLUSH_ZERO) begin
                        state_r      <= IDLE;
                        filt_rst_n_r <= 1'b0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - FLUSH_ONE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    filt_x_r     <= {N{1'b0}};
                    filt_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

    // Issue flags travel alongside the filter latency to mark valid results.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r <= {LAT{1'b0}};
        end else begin
            vld_pipe_r[0] <= iss_r;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
            end
        end
    end

    assign filt_x       = filt_x_r;
    assign filt_rst_n   = filt_rst_n_r;
    assign out_data     = filt_y;
    assign out_valid    = vld_pipe_r[LAT-1];
    assign busy         = (state_r != IDLE);
    assign err_underrun = err_underrun_r;
    assign sample_cnt   = sample_cnt_r;
endmodule

// File: tb/tb_wma_seq.sv
// Directed bench for wma_seq at default parameters: vector table plus hand-written multi-cycle sequences.
module tb_wma_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [7:0]  filt_x;
    logic        filt_rst_n;
    logic [7:0]  filt_y;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        err_underrun;
    logic [15:0] sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [7:0]  din;
        logic        en;
        logic        rdy;
        logic [7:0]  fx;
        logic        frn;
        logic        ov;
        logic        busy;
        logic        err;
        logic [15:0] scnt;
    } vec_t;

    vec_t tbl[$];

    wma_seq #(.N(8), .TAPS(4), .LAT(1), .DEPTH(8), .START_LVL(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .enable(enable), .filt_x(filt_x), .filt_rst_n(filt_rst_n), .filt_y(filt_y),
        .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .err_underrun(err_underrun), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic e,
                       input logic rdy, input logic [7:0] fx, input logic frn, input logic ov,
                       input logic bsy, input logic err, input logic [15:0] scnt);
        vec_t x;
        x.rst = r; x.vin = v; x.din = d; x.en = e; x.rdy = rdy; x.fx = fx;
        x.frn = frn; x.ov = ov; x.busy = bsy; x.err = err; x.scnt = scnt;
        tbl.push_back(x);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic e);
        rst = r; in_valid = v; in_data = d; enable = e;
        filt_y = filt_y + 8'd37;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; enable = 1'b0; filt_y = 8'h00;

        // reset
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        // fill with enable low: 8 accepted, full from the 8th write on
        for (int d = 1; d <= 9; d++) begin
            add(1'b0, 1'b1, 8'(d), 1'b0, (d <= 7) ? 1'b1 : 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        // single burst
        for (int d = 1; d <= 4; d++) begin
            add(1'b0, 1'b1, 8'(d), 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        add(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        add(1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3);
        add(1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b0, 16'd6);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 16'd7);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 16'd8);
`ifdef WMA_SEQ_HOLD_EN
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1, 16'd8);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'd8);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
`else
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'd8);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
`endif

        foreach (tbl[i]) begin
            logic [7:0] fy;
            fy = 8'hC3 ^ 8'(i);
            rst = tbl[i].rst; in_valid = tbl[i].vin; in_data = tbl[i].din;
            enable = tbl[i].en; filt_y = fy;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d in_ready", i),   {15'd0, in_ready},     {15'd0, tbl[i].rdy});
            chk($sformatf("row%0d filt_x", i),     {8'd0, filt_x},        {8'd0, tbl[i].fx});
            chk($sformatf("row%0d filt_rst_n", i), {15'd0, filt_rst_n},   {15'd0, tbl[i].frn});
            chk($sformatf("row%0d out_valid", i),  {15'd0, out_valid},    {15'd0, tbl[i].ov});
            chk($sformatf("row%0d busy", i),       {15'd0, busy},         {15'd0, tbl[i].busy});
            chk($sformatf("row%0d err", i),        {15'd0, err_underrun}, {15'd0, tbl[i].err});
            chk($sformatf("row%0d sample_cnt", i), sample_cnt,            tbl[i].scnt);
            chk($sformatf("row%0d out_data", i),   {8'd0, out_data},      {8'd0, fy});
        end

        // enable drop after 3 pops; err_underrun left set by the burst must clear on start
        for (int d = 0; d < 8; d++) step(1'b0, 1'b1, 8'h11 + 8'(d), 1'b0);
        chk("drop full", {15'd0, in_ready}, 16'd0);
        chk("drop idle", {15'd0, busy}, 16'd0);
        for (int p = 0; p < 3; p++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drop fx", {8'd0, filt_x}, {8'd0, 8'h11 + 8'(p)});
            chk("drop ov", {15'd0, out_valid}, 16'd0);
        end
        chk("drop err cleared", {15'd0, err_underrun}, 16'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop fx zero", {8'd0, filt_x}, 16'd0);
        chk("drop flush", {15'd0, busy}, 16'd1);
        chk("drop ov flush", {15'd0, out_valid}, 16'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop back idle", {15'd0, busy}, 16'd0);
        chk("drop frn", {15'd0, filt_rst_n}, 16'd0);
        chk("drop no err", {15'd0, err_underrun}, 16'd0);
        // drain the 5 remaining samples
        for (int p = 0; p < 5; p++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain fx", {8'd0, filt_x}, {8'd0, 8'h14 + 8'(p)});
            chk("drain cnt", sample_cnt, 16'(p + 1));
        end
        // write coinciding with the empty-FIFO pop attempt
        step(1'b0, 1'b1, 8'h99, 1'b1);
        chk("urun err", {15'd0, err_underrun}, 16'd1);
        chk("urun ov", {15'd0, out_valid}, 16'd1);
`ifdef WMA_SEQ_HOLD_EN
        chk("urun hold fx", {8'd0, filt_x}, 16'h0018);
        chk("urun still run", {15'd0, busy}, 16'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("urun resume fx", {8'd0, filt_x}, 16'h0099);
        chk("urun resume cnt", sample_cnt, 16'd6);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("urun idle", {15'd0, busy}, 16'd0);
`else
        chk("urun fx zero", {8'd0, filt_x}, 16'd0);
        chk("urun flush", {15'd0, busy}, 16'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("urun idle", {15'd0, busy}, 16'd0);
        chk("urun cnt", sample_cnt, 16'd5);
`endif

        // reset in the middle of a valid-output run
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int d = 0; d < 8; d++) step(1'b0, 1'b1, 8'h21 + 8'(d), 1'b0);
        for (int p = 0; p < 6; p++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("mid fx", {8'd0, filt_x}, {8'd0, 8'h21 + 8'(p)});
        end
        chk("mid ov before rst", {15'd0, out_valid}, 16'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("mid rst busy", {15'd0, busy}, 16'd0);
        chk("mid rst frn", {15'd0, filt_rst_n}, 16'd0);
        chk("mid rst ov", {15'd0, out_valid}, 16'd0);
        chk("mid rst fx", {8'd0, filt_x}, 16'd0);
        chk("mid rst cnt", sample_cnt, 16'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid rst fifo empty", {15'd0, busy}, 16'd0);

`ifdef WMA_SEQ_HOLD_EN
        // hold: FIFO runs dry for 2 cycles inside a burst
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int d = 1; d <= 4; d++) step(1'b0, 1'b1, 8'(d), 1'b1);
        for (int p = 1; p <= 4; p++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("hold fx", {8'd0, filt_x}, 16'(p));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("hold1 fx", {8'd0, filt_x}, 16'h0004);
        chk("hold1 err", {15'd0, err_underrun}, 16'd1);
        chk("hold1 run", {15'd0, busy}, 16'd1);
        step(1'b0, 1'b1, 8'h05, 1'b1);
        chk("hold2 fx", {8'd0, filt_x}, 16'h0004);
        chk("hold2 ov", {15'd0, out_valid}, 16'd0);
        chk("hold2 run", {15'd0, busy}, 16'd1);
        step(1'b0, 1'b1, 8'h06, 1'b1);
        chk("hold fx5", {8'd0, filt_x}, 16'h0005);
        chk("hold ov5", {15'd0, out_valid}, 16'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("hold fx6", {8'd0, filt_x}, 16'h0006);
        chk("hold ov6", {15'd0, out_valid}, 16'd1);
        chk("hold cnt", sample_cnt, 16'd6);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("hold end idle", {15'd0, busy}, 16'd0);
        chk("hold end cnt", sample_cnt, 16'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
